// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline sequencer for the 5-stage OpenMIPS core.
//
// Merges the per-stage stall requests into the stall[5:0] hold vector. Turns a
// MEM-stage exception into a single-cycle flush with a redirect PC. After each
// flush it holds a refill window during which further exceptions are ignored.
// It also keeps saturating stall/flush counters and a sticky stall watchdog.
//
// Ports
//   clk, rst         clock; synchronous active-high reset
//   stallreq_if/id/ex/mem  per-stage stall requests
//   excepttype_i     MEM-stage exception code (0 = none)
//   cp0_epc_i        EPC from CP0; this is the return target for ERET
//   stall[5:0]       hold vector: [0]PC [1]IF [2]ID [3]EX [4]MEM [5]WB
//   flush            flush all pipeline registers this cycle
//   new_pc           redirect PC while flush=1, otherwise 0
//   stall_cnt        saturating count of cycles with stall != 0
//   flush_cnt        saturating count of accepted flushes
//   wdt_timeout      sticky; set after WDT_LIMIT consecutive stalled cycles
//   dbg_state        FSM state (0 = RUN, 1 = REFILL)
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR    = 32'h0000_0020,
  parameter int          REFILL_CYCLES = 3,
  parameter int          WDT_LIMIT     = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic [31:0] stall_cnt,
  output logic [15:0] flush_cnt,
  output logic        wdt_timeout,
  output logic        dbg_state
);

  localparam int RW = $clog2(REFILL_CYCLES) + 1;
  localparam int WW = $clog2(WDT_LIMIT) + 1;
  localparam logic [RW-1:0] REFILL_LOAD = RW'(REFILL_CYCLES - 1);
  localparam logic [WW-1:0] WDT_LAST    = WW'(WDT_LIMIT - 1);
  localparam logic [31:0]   ERET_CODE   = 32'h0000_000e;

  typedef enum logic {
    S_RUN    = 1'b0,
    S_REFILL = 1'b1
  } state_t;

  state_t          r_state;
  logic [RW-1:0]   r_refill_cnt;
  logic [31:0]     r_stall_cnt;
  logic [15:0]     r_flush_cnt;
  logic [WW-1:0]   r_wdt_cnt;
  logic            r_wdt_timeout;

  logic            w_exc_valid;
  logic [5:0]      w_stall;
  logic            w_flush;
  logic [31:0]     w_new_pc;
  logic            w_stalled;

  // Stall and flush are combinational so the pipeline registers see them at
  // the same edge as the request. An accepted exception overrides every stall
  // request, because the flushed instructions are discarded anyway.
  always_comb begin
    w_exc_valid = (excepttype_i != 32'd0) && (r_state == S_RUN);
    w_stall     = 6'b000000;
    w_flush     = 1'b0;
    w_new_pc    = 32'd0;
    if (w_exc_valid) begin
      w_flush  = 1'b1;
      w_new_pc = (excepttype_i == ERET_CODE) ? cp0_epc_i : EXC_VECTOR;
    end else if (stallreq_mem) begin
      w_stall = 6'b011111;
    end else if (stallreq_ex) begin
      w_stall = 6'b001111;
    end else if (stallreq_id) begin
      w_stall = 6'b000111;
    end else if (stallreq_if) begin
      w_stall = 6'b000011;
    end
    w_stalled = (w_stall != 6'b000000);
  end

  // In REFILL, MEM still holds the old exception code until the flush has
  // drained it; the window keeps that stale code from flushing again.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_RUN;
      r_refill_cnt <= '0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_exc_valid) begin
            r_state      <= S_REFILL;
            r_refill_cnt <= REFILL_LOAD;
          end
        end
        S_REFILL: begin
          if (r_refill_cnt == '0) begin
            r_state <= S_RUN;
          end else begin
            r_refill_cnt <= r_refill_cnt - 1'b1;
          end
        end
        default: begin
          r_state      <= S_RUN;
          r_refill_cnt <= '0;
        end
      endcase
    end
  end

  // Performance counters saturate rather than wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= 32'd0;
      r_flush_cnt <= 16'd0;
    end else begin
      if (w_stalled && (r_stall_cnt != 32'hFFFF_FFFF)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if (w_flush && (r_flush_cnt != 16'hFFFF)) begin
        r_flush_cnt <= r_flush_cnt + 16'd1;
      end
    end
  end

  // The watchdog count holds at WDT_LAST. Seeing that value on another stalled
  // cycle means WDT_LIMIT stalled cycles in a row, so the sticky flag is set.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wdt_cnt     <= '0;
      r_wdt_timeout <= 1'b0;
    end else if (w_stalled) begin
      if (r_wdt_cnt == WDT_LAST) begin
        r_wdt_timeout <= 1'b1;
      end else begin
        r_wdt_cnt <= r_wdt_cnt + 1'b1;
      end
    end else begin
      r_wdt_cnt <= '0;
    end
  end

  assign stall       = w_stall;
  assign flush       = w_flush;
  assign new_pc      = w_new_pc;
  assign stall_cnt   = r_stall_cnt;
  assign flush_cnt   = r_flush_cnt;
  assign wdt_timeout = r_wdt_timeout;
  assign dbg_state   = (r_state == S_REFILL);

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

  localparam int REFILL_CYCLES = 3;
  localparam int WDT_LIMIT     = 1024;
  localparam logic [31:0] EXC_VECTOR = 32'h0000_0020;

  logic        clk;
  logic        rst;
  logic        stallreq_if;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic        stallreq_mem;
  logic [31:0] excepttype_i;
  logic [31:0] cp0_epc_i;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic [31:0] stall_cnt;
  logic [15:0] flush_cnt;
  logic        wdt_timeout;
  logic        dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model. It tracks remaining ignored cycles, raw counts and the
  // current stall run length rather than any FSM.
  int      m_ignore    = 0;
  longint  m_stall_cnt = 0;
  int      m_flush_cnt = 0;
  int      m_run       = 0;
  bit      m_wdt       = 0;

  pipe_ctrl #(
    .EXC_VECTOR(EXC_VECTOR),
    .REFILL_CYCLES(REFILL_CYCLES),
    .WDT_LIMIT(WDT_LIMIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .stallreq_if(stallreq_if),
    .stallreq_id(stallreq_id),
    .stallreq_ex(stallreq_ex),
    .stallreq_mem(stallreq_mem),
    .excepttype_i(excepttype_i),
    .cp0_epc_i(cp0_epc_i),
    .stall(stall),
    .flush(flush),
    .new_pc(new_pc),
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt),
    .wdt_timeout(wdt_timeout),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Hold vector: the highest requesting stage and every stage before it,
  // plus the PC.
  function automatic logic [5:0] model_stall(input logic [3:0] req);
    int top = -1;
    for (int i = 0; i < 4; i++) if (req[i]) top = i;
    if (top < 0) return 6'd0;
    return 6'((1 << (top + 2)) - 1);
  endfunction

  task automatic set_in(input bit r, input logic [3:0] req, input logic [31:0] exc,
                        input logic [31:0] epc);
    rst          = r;
    stallreq_if  = req[0];
    stallreq_id  = req[1];
    stallreq_ex  = req[2];
    stallreq_mem = req[3];
    excepttype_i = exc;
    cp0_epc_i    = epc;
  endtask

  // One cycle: inputs were driven just after a negedge. The task checks the
  // combinational outputs, advances the model at posedge, then checks the
  // registered outputs.
  task automatic step(input string tag);
    bit          exc;
    logic [5:0]  e_stall;
    logic [31:0] e_pc;
    #1;
    exc     = (excepttype_i != 32'd0) && (m_ignore == 0);
    e_stall = exc ? 6'd0 : model_stall({stallreq_mem, stallreq_ex, stallreq_id, stallreq_if});
    e_pc    = !exc ? 32'd0 : (excepttype_i == 32'he) ? cp0_epc_i : EXC_VECTOR;
    check({tag, ".stall"}, 32'(stall), 32'(e_stall));
    check({tag, ".flush"}, 32'(flush), 32'(exc));
    check({tag, ".new_pc"}, new_pc, e_pc);
    @(posedge clk);
    if (rst) begin
      m_ignore = 0; m_stall_cnt = 0; m_flush_cnt = 0; m_run = 0; m_wdt = 0;
    end else begin
      if (exc) m_ignore = REFILL_CYCLES;
      else if (m_ignore > 0) m_ignore--;
      if (e_stall != 0) begin
        if (m_stall_cnt < 64'hFFFF_FFFF) m_stall_cnt++;
        m_run++;
        if (m_run >= WDT_LIMIT) m_wdt = 1;
      end else begin
        m_run = 0;
      end
      if (exc && m_flush_cnt < 65535) m_flush_cnt++;
    end
    #1;
    check({tag, ".stall_cnt"}, stall_cnt, 32'(m_stall_cnt));
    check({tag, ".flush_cnt"}, 32'(flush_cnt), 32'(m_flush_cnt));
    check({tag, ".wdt"}, 32'(wdt_timeout), 32'(m_wdt));
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] codes [4];
    codes[0] = 32'h8; codes[1] = 32'hc; codes[2] = 32'he; codes[3] = 32'h4;

    set_in(1'b1, 4'b0000, 32'd0, 32'd0);
    @(negedge clk);
    step("reset0");
    step("reset1");
    set_in(1'b0, 4'b0000, 32'd0, 32'd0);
    step("idle");

    // ID and EX together: EX wins
    set_in(1'b0, 4'b0110, 32'd0, 32'd0);
    step("id_ex");
    check("id_ex.direct", 32'(stall_cnt), 32'd1);

    // exception plus MEM stall: flush wins, then three ignored cycles
    set_in(1'b0, 4'b1000, 32'h8, 32'd0);
    step("exc_mem");
    check("exc_mem.flush_cnt", 32'(flush_cnt), 32'd1);
    set_in(1'b0, 4'b0000, 32'hc, 32'd0);
    for (int i = 0; i < REFILL_CYCLES; i++) step("refill_ignore");
    step("refill_done");

    // ERET redirect to EPC
    set_in(1'b0, 4'b0000, 32'd0, 32'd0);
    for (int i = 0; i < 4; i++) step("drain");
    set_in(1'b0, 4'b0001, 32'he, 32'h0000_1234);
    step("eret");

    // reset in the middle of REFILL, then an exception right after
    set_in(1'b0, 4'b0000, 32'd0, 32'd0);
    for (int i = 0; i < 4; i++) step("drain2");
    set_in(1'b0, 4'b0000, 32'h8, 32'd0);
    step("exc_pre_rst");
    set_in(1'b1, 4'b0000, 32'h8, 32'd0);
    step("rst_mid_refill");
    set_in(1'b0, 4'b0000, 32'h8, 32'd0);
    step("exc_post_rst");
    check("exc_post_rst.flush_cnt", 32'(flush_cnt), 32'd1);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [3:0]  req;
      logic [31:0] exc;
      req = 4'd0;
      for (int k = 0; k < 4; k++) req[k] = ($urandom_range(0, 3) == 0);
      exc = 32'd0;
      if ($urandom_range(0, 5) == 0) exc = codes[$urandom_range(0, 3)];
      if ($urandom_range(0, 19) == 0) exc = $urandom;
      set_in(($urandom_range(0, 49) == 0), req, exc, $urandom);
      step("rand");
    end

    // watchdog: 1023 stalled cycles is not enough, 1024 is
    set_in(1'b1, 4'b0000, 32'd0, 32'd0);
    step("wdt_rst");
    set_in(1'b0, 4'b0001, 32'd0, 32'd0);
    for (int i = 0; i < WDT_LIMIT - 1; i++) step("wdt_run");
    check("wdt_1023", 32'(wdt_timeout), 32'd0);
    step("wdt_last");
    check("wdt_1024", 32'(wdt_timeout), 32'd1);
    set_in(1'b0, 4'b0000, 32'd0, 32'd0);
    step("wdt_drop");
    step("wdt_sticky");
    check("wdt_sticky.direct", 32'(wdt_timeout), 32'd1);

    // stall counter saturation via backdoor preload
    force dut.r_stall_cnt = 32'hFFFF_FFFD;
    m_stall_cnt = 64'hFFFF_FFFD;
    step("preload");
    release dut.r_stall_cnt;
    set_in(1'b0, 4'b0100, 32'd0, 32'd0);
    for (int i = 0; i < 5; i++) step("sat");
    check("sat.direct", stall_cnt, 32'hFFFF_FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // overall time bound
  initial begin
    #200000;
    $display("FAIL timeout reached before end of sequence");
    $fatal(1, "timeout");
  end

endmodule
